// File: rtl/ap_chain_driver.sv
// ap_chain_driver: issues a configured number of ap_ctrl_chain transactions and timestamps each start to report latency.
// Optional macro AP_CHAIN_BACKPRESSURE_EN adds the cont_hold input that stalls ap_continue.
module ap_chain_driver #(
    parameter int CNT_W = 16,
    parameter int LAT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_go,
    input  logic [CNT_W-1:0] cfg_num_txn,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
`ifdef AP_CHAIN_BACKPRESSURE_EN
    input  logic             cont_hold,
`endif
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] txn_started,
    output logic [CNT_W-1:0] txn_done,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] max_latency,
    output logic             proto_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] num_reg;
    logic [CNT_W-1:0] started_reg;
    logic [CNT_W-1:0] done_reg;
    logic [LAT_W-1:0] cycle_reg;
    logic [LAT_W-1:0] last_lat_reg;
    logic [LAT_W-1:0] max_lat_reg;
    logic             proto_err_reg;
    logic             start_raised_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [LAT_W-1:0] ts_mem [DEPTH];

    logic             active;
    logic             go_ok;
    logic             hold_ok;
    logic             start_accept;
    logic             done_ack;
    logic             fifo_empty;
    logic             pop;
    logic [LAT_W-1:0] head_ts;
    logic [LAT_W-1:0] new_lat;

    assign active = (state_reg == RUN) || (state_reg == DRAIN);
    assign go_ok  = cfg_go && ((state_reg == IDLE) || (state_reg == DONE));

`ifdef AP_CHAIN_BACKPRESSURE_EN
    assign hold_ok = ~cont_hold;
`else
    assign hold_ok = 1'b1;
`endif

    // The FIFO-full test only gates raising; a request already on the wire is held until accepted.
    assign ap_start = (state_reg == RUN) && (started_reg < num_reg) &&
                      (start_raised_reg || (count_reg < (PTR_W+1)'(DEPTH)));
    assign ap_continue = ap_done && active && hold_ok;

    assign start_accept = ap_start && ap_ready;
    assign done_ack     = ap_done && ap_continue;
    assign fifo_empty   = (count_reg == '0);
    assign pop          = done_ack && !fifo_empty;

    // The head is needed in the ack cycle itself, so the timestamp store is read asynchronously.
    assign head_ts = ts_mem[rd_ptr_reg];
    assign new_lat = cycle_reg - head_ts;

    assign busy         = active;
    assign finish       = (state_reg == DONE);
    assign txn_started  = started_reg;
    assign txn_done     = done_reg;
    assign last_latency = last_lat_reg;
    assign max_latency  = max_lat_reg;
    assign proto_err    = proto_err_reg;

    always_ff @(posedge clock) begin
        if (start_accept) begin
            ts_mem[wr_ptr_reg] <= cycle_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            num_reg          <= '0;
            started_reg      <= '0;
            done_reg         <= '0;
            cycle_reg        <= '0;
            last_lat_reg     <= '0;
            max_lat_reg      <= '0;
            proto_err_reg    <= 1'b0;
            start_raised_reg <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
        end else if (go_ok) begin
            state_reg        <= (cfg_num_txn == '0) ? DONE : RUN;
            num_reg          <= cfg_num_txn;
            started_reg      <= '0;
            done_reg         <= '0;
            cycle_reg        <= '0;
            last_lat_reg     <= '0;
            max_lat_reg      <= '0;
            proto_err_reg    <= 1'b0;
            start_raised_reg <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
        end else begin
            // Transitions look at the registered counters, so they land one cycle after the count is reached.
            case (state_reg)
                RUN:     if (started_reg == num_reg) state_reg <= DRAIN;
                DRAIN:   if (done_reg == num_reg) state_reg <= DONE;
                default: state_reg <= state_reg;
            endcase

            if (active) begin
                cycle_reg <= cycle_reg + LAT_W'(1);
            end

            start_raised_reg <= ap_start && !ap_ready;

            if (start_accept) begin
                started_reg <= started_reg + CNT_W'(1);
                wr_ptr_reg  <= wr_ptr_reg + PTR_W'(1);
            end

            if (pop) begin
                done_reg     <= done_reg + CNT_W'(1);
                rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
                last_lat_reg <= new_lat;
                if (new_lat > max_lat_reg) begin
                    max_lat_reg <= new_lat;
                end
            end

            if (done_ack && fifo_empty) begin
                proto_err_reg <= 1'b1;
            end

            case ({start_accept, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_chain_driver.sv
// Self-checking bench for ap_chain_driver: directed scenarios plus a randomized run against a cycle-stamped transaction model.
module tb_ap_chain_driver;
    localparam int CNT_W = 16;
    localparam int LAT_W = 32;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_go = 1'b0;
    logic [CNT_W-1:0] cfg_num_txn = '0;
    logic             ap_start;
    logic             ap_ready = 1'b0;
    logic             ap_done = 1'b0;
    logic             ap_continue;
`ifdef AP_CHAIN_BACKPRESSURE_EN
    logic             cont_hold = 1'b0;
`endif
    logic             busy;
    logic             finish;
    logic [CNT_W-1:0] txn_started;
    logic [CNT_W-1:0] txn_done;
    logic [LAT_W-1:0] last_latency;
    logic [LAT_W-1:0] max_latency;
    logic             proto_err;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ap_chain_driver #(.CNT_W(CNT_W), .LAT_W(LAT_W), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_go       (cfg_go),
        .cfg_num_txn  (cfg_num_txn),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
`ifdef AP_CHAIN_BACKPRESSURE_EN
        .cont_hold    (cont_hold),
`endif
        .busy         (busy),
        .finish       (finish),
        .txn_started  (txn_started),
        .txn_done     (txn_done),
        .last_latency (last_latency),
        .max_latency  (max_latency),
        .proto_err    (proto_err)
    );

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] n);
        cfg_go = 1'b1;
        cfg_num_txn = n;
        next_cycle();
        cfg_go = 1'b0;
    endtask

    task automatic test_reset;
        ap_ready = 1'b1;
        ap_done = 1'b1;
        @(negedge clock);
        checks++;
        if (ap_start !== 1'b0 || ap_continue !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: ap_start=%b ap_continue=%b required 0 0", ap_start, ap_continue);
        end
        checks++;
        if (busy !== 1'b0 || finish !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b finish=%b proto_err=%b required 0 0 0", busy, finish, proto_err);
        end
        checks++;
        if (txn_started !== '0 || txn_done !== '0 || last_latency !== '0 || max_latency !== '0) begin
            errors++;
            $display("FAIL reset_counters: started=%0d done=%0d last=%0d max=%0d required all 0",
                     txn_started, txn_done, last_latency, max_latency);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (ap_continue !== 1'b0 || ap_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: ap_continue=%b ap_start=%b busy=%b required 0 0 0", ap_continue, ap_start, busy);
        end
        next_cycle();
        ap_ready = 1'b0;
        ap_done = 1'b0;
        $display("test_reset: reset and idle outputs checked");
    endtask

    task automatic test_single;
        start_run(CNT_W'(1));
        ap_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (ap_start !== 1'b1) begin
            errors++;
            $display("FAIL single_start: ap_start=%b required 1", ap_start);
        end
        next_cycle();
        ap_ready = 1'b0;
        checks++;
        if (txn_started !== CNT_W'(1) || ap_start !== 1'b0) begin
            errors++;
            $display("FAIL single_accepted: started=%0d ap_start=%b required 1 0", txn_started, ap_start);
        end
        repeat (4) next_cycle();
        ap_done = 1'b1;
        @(negedge clock);
        checks++;
        if (ap_continue !== 1'b1) begin
            errors++;
            $display("FAIL single_continue: ap_continue=%b required 1", ap_continue);
        end
        next_cycle();
        ap_done = 1'b0;
        checks++;
        if (txn_done !== CNT_W'(1) || last_latency !== LAT_W'(5) || max_latency !== LAT_W'(5)) begin
            errors++;
            $display("FAIL single_latency: done=%0d last=%0d max=%0d required 1 5 5", txn_done, last_latency, max_latency);
        end
        checks++;
        if (finish !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_early_finish: finish=%b busy=%b required 0 1", finish, busy);
        end
        next_cycle();
        checks++;
        if (finish !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_finish: finish=%b busy=%b required 1 0", finish, busy);
        end
        $display("test_single: one transaction, latency 5");
    endtask

    task automatic test_proto_err;
        start_run(CNT_W'(1));
        ap_done = 1'b1;
        @(negedge clock);
        checks++;
        if (ap_continue !== 1'b1) begin
            errors++;
            $display("FAIL proto_continue: ap_continue=%b required 1", ap_continue);
        end
        next_cycle();
        ap_done = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || txn_done !== '0) begin
            errors++;
            $display("FAIL proto_flag: proto_err=%b done=%0d required 1 0", proto_err, txn_done);
        end
        ap_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (ap_start !== 1'b1) begin
            errors++;
            $display("FAIL proto_start: ap_start=%b required 1", ap_start);
        end
        next_cycle();
        ap_ready = 1'b0;
        next_cycle();
        ap_done = 1'b1;
        next_cycle();
        ap_done = 1'b0;
        checks++;
        if (txn_done !== CNT_W'(1) || last_latency !== LAT_W'(2) || max_latency !== LAT_W'(2) || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_recover: done=%0d last=%0d max=%0d proto_err=%b required 1 2 2 1",
                     txn_done, last_latency, max_latency, proto_err);
        end
        next_cycle();
        checks++;
        if (finish !== 1'b1) begin
            errors++;
            $display("FAIL proto_finish: finish=%b required 1", finish);
        end
        cfg_go = 1'b1;
        cfg_num_txn = '0;
        @(negedge clock);
        checks++;
        if (ap_start !== 1'b0) begin
            errors++;
            $display("FAIL rezero_start: ap_start=%b required 0", ap_start);
        end
        next_cycle();
        cfg_go = 1'b0;
        checks++;
        if (finish !== 1'b1 || busy !== 1'b0 || proto_err !== 1'b0 || txn_started !== '0 || txn_done !== '0 ||
            last_latency !== '0 || max_latency !== '0) begin
            errors++;
            $display("FAIL go_clears: finish=%b busy=%b proto_err=%b started=%0d done=%0d last=%0d max=%0d required 1 0 0 0 0 0 0",
                     finish, busy, proto_err, txn_started, txn_done, last_latency, max_latency);
        end
        $display("test_proto_err: unmatched done flagged, cleared by next go");
    endtask

    task automatic test_zero;
        bit saw_start;
        do_reset();
        cfg_go = 1'b1;
        cfg_num_txn = '0;
        ap_ready = 1'b1;
        next_cycle();
        cfg_go = 1'b0;
        checks++;
        if (finish !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_finish: finish=%b busy=%b required 1 0", finish, busy);
        end
        saw_start = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (ap_start !== 1'b0) saw_start = 1'b1;
            next_cycle();
        end
        checks++;
        if (saw_start || txn_started !== '0) begin
            errors++;
            $display("FAIL zero_no_start: saw_start=%b started=%0d required 0 0", saw_start, txn_started);
        end
        ap_ready = 1'b0;
        $display("test_zero: zero-count run finishes without starts");
    endtask

    task automatic test_same_cycle;
        do_reset();
        start_run(CNT_W'(4));
        ap_ready = 1'b1;
        repeat (2) next_cycle();
        ap_ready = 1'b0;
        next_cycle();
        ap_ready = 1'b1;
        ap_done = 1'b1;
        @(negedge clock);
        checks++;
        if (ap_start !== 1'b1 || ap_continue !== 1'b1) begin
            errors++;
            $display("FAIL same_handshake: ap_start=%b ap_continue=%b required 1 1", ap_start, ap_continue);
        end
        next_cycle();
        ap_ready = 1'b0;
        ap_done = 1'b0;
        checks++;
        if (txn_started !== CNT_W'(3) || txn_done !== CNT_W'(1) || last_latency !== LAT_W'(3)) begin
            errors++;
            $display("FAIL same_counts: started=%0d done=%0d last=%0d required 3 1 3", txn_started, txn_done, last_latency);
        end
        // Two outstanding remain: two more starts are allowed before the FIFO fills.
        ap_ready = 1'b1;
        repeat (3) next_cycle();
        ap_ready = 1'b0;
        checks++;
        if (txn_started !== CNT_W'(4) || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL same_followup: started=%0d proto_err=%b required 4 0", txn_started, proto_err);
        end
        $display("test_same_cycle: simultaneous accept and ack");
    endtask

    task automatic test_depth;
        int accepts;
        do_reset();
        start_run(CNT_W'(8));
        ap_ready = 1'b1;
        accepts = 0;
        repeat (12) begin
            @(negedge clock);
            if (ap_start === 1'b1) accepts++;
            next_cycle();
        end
        @(negedge clock);
        checks++;
        if (accepts != DEPTH || txn_started !== CNT_W'(DEPTH)) begin
            errors++;
            $display("FAIL depth_accepts: accepts=%0d started=%0d required %0d", accepts, txn_started, DEPTH);
        end
        checks++;
        if (ap_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL depth_stall: ap_start=%b busy=%b required 0 1", ap_start, busy);
        end
        next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (txn_started !== '0 || busy !== 1'b0 || ap_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: started=%0d busy=%b ap_start=%b required 0 0 0", txn_started, busy, ap_start);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (ap_start !== 1'b0 || busy !== 1'b0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: ap_start=%b busy=%b finish=%b required 0 0 0", ap_start, busy, finish);
        end
        next_cycle();
        ap_ready = 1'b0;
        $display("test_depth: outstanding capped at %0d, reset aborts run", DEPTH);
    endtask

    task automatic test_random;
        int unsigned      q_acc[$];
        int unsigned      q_due[$];
        int               n;
        int               m_started;
        int               m_done;
        int               ready_pct;
        logic [LAT_W-1:0] m_last;
        logic [LAT_W-1:0] m_max;
        logic [LAT_W-1:0] lat;
        bit               prev_pending;
        bit               finished;
        do_reset();
        for (int run = 0; run < 6; run++) begin
            n = $urandom_range(1, 20);
            ready_pct = $urandom_range(30, 100);
            m_started = 0;
            m_done = 0;
            m_last = '0;
            m_max = '0;
            prev_pending = 1'b0;
            finished = 1'b0;
            q_acc.delete();
            q_due.delete();
            start_run(CNT_W'(n));
            for (int k = 0; k < 3000 && !finished; k++) begin
                ap_ready = ($urandom_range(1, 100) <= ready_pct);
                ap_done = (q_due.size() > 0) && (q_due[0] <= cyc);
                @(negedge clock);
                checks++;
                if (txn_started !== CNT_W'(m_started) || txn_done !== CNT_W'(m_done)) begin
                    errors++;
                    $display("FAIL rand_counts: run=%0d started=%0d done=%0d required %0d %0d",
                             run, txn_started, txn_done, m_started, m_done);
                end
                checks++;
                if (last_latency !== m_last || max_latency !== m_max || proto_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_latency: run=%0d last=%0d max=%0d proto_err=%b required %0d %0d 0",
                             run, last_latency, max_latency, proto_err, m_last, m_max);
                end
                if (prev_pending) begin
                    checks++;
                    if (ap_start !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_start_hold: run=%0d ap_start=%b required 1", run, ap_start);
                    end
                end
                if (ap_start === 1'b1) begin
                    checks++;
                    if (!(m_started < n && (m_started - m_done) < DEPTH)) begin
                        errors++;
                        $display("FAIL rand_start_allowed: run=%0d ap_start=1 started=%0d done=%0d n=%0d required 0",
                                 run, m_started, m_done, n);
                    end
                end
                if (finish === 1'b1) begin
                    finished = 1'b1;
                    checks++;
                    if (m_done != n || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_finish: run=%0d model_done=%0d busy=%b required %0d 0", run, m_done, busy, n);
                    end
                end else begin
                    checks++;
                    if (busy !== 1'b1 || ap_continue !== ap_done) begin
                        errors++;
                        $display("FAIL rand_busy: run=%0d busy=%b ap_continue=%b required 1 %b", run, busy, ap_continue, ap_done);
                    end
                end
                if (ap_done === 1'b1 && ap_continue === 1'b1 && q_acc.size() > 0) begin
                    lat = LAT_W'(cyc - q_acc.pop_front());
                    void'(q_due.pop_front());
                    m_last = lat;
                    if (lat > m_max) m_max = lat;
                    m_done++;
                end
                if (ap_start === 1'b1 && ap_ready === 1'b1) begin
                    q_acc.push_back(cyc);
                    q_due.push_back(cyc + $urandom_range(1, 8));
                    m_started++;
                end
                prev_pending = (ap_start === 1'b1) && !ap_ready;
                next_cycle();
            end
            ap_ready = 1'b0;
            ap_done = 1'b0;
            if (!finished) begin
                checks++;
                errors++;
                $display("FAIL rand_timeout: run=%0d finish never rose, started=%0d done=%0d", run, txn_started, txn_done);
            end
            $display("test_random: run %0d n=%0d ready%%=%0d max_latency=%0d", run, n, ready_pct, m_max);
        end
    endtask

`ifdef AP_CHAIN_BACKPRESSURE_EN
    task automatic test_backpressure;
        int low_cycles;
        do_reset();
        start_run(CNT_W'(1));
        ap_ready = 1'b1;
        next_cycle();
        ap_ready = 1'b0;
        next_cycle();
        ap_done = 1'b1;
        cont_hold = 1'b1;
        low_cycles = 0;
        repeat (3) begin
            @(negedge clock);
            if (ap_continue === 1'b0) low_cycles++;
            next_cycle();
        end
        cont_hold = 1'b0;
        @(negedge clock);
        checks++;
        if (low_cycles != 3 || ap_continue !== 1'b1) begin
            errors++;
            $display("FAIL hold_gate: low_cycles=%0d ap_continue=%b required 3 1", low_cycles, ap_continue);
        end
        next_cycle();
        ap_done = 1'b0;
        checks++;
        if (last_latency !== LAT_W'(5) || txn_done !== CNT_W'(1)) begin
            errors++;
            $display("FAIL hold_latency: last=%0d done=%0d required 5 1", last_latency, txn_done);
        end
        $display("test_backpressure: cont_hold stretches latency by 3");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_proto_err();
        test_zero();
        test_same_cycle();
        test_depth();
        test_random();
`ifdef AP_CHAIN_BACKPRESSURE_EN
        test_backpressure();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
